// File: rtl/mem_burst_responder_pkg.sv
// Shared definitions for the memory burst responder: FSM states,
// default sizing and the block-base helper.
package mem_pkg;

  localparam int ADDR_W_DEF         = 16;
  localparam int DATA_W_DEF         = 16;
  localparam int BURST_DEF          = 8;
  localparam int LATENCY_DEF        = 4;
  localparam int MEM_WORDS_LOG2_DEF = 10;

  // Bits needed to index a word inside a block of BURST_DEF words.
  localparam int BLOCK_OFF_W = $clog2(BURST_DEF);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN
  } state_t;

  // Clears the byte-offset bit plus the word-in-block bits of an address.
  function automatic logic [ADDR_W_DEF-1:0] block_base(
    input logic [ADDR_W_DEF-1:0] addr,
    input int unsigned           off_w
  );
    logic [ADDR_W_DEF-1:0] mask;
    mask = '1;
    mask = mask << (off_w + 1);
    return addr & mask;
  endfunction

endpackage

// File: rtl/mem_burst_responder_if.sv
// Bus between a cache fill controller / data cache (master) and the
// memory burst responder (slave).
interface mem_burst_responder_if
  import mem_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);

  logic              req_valid;
  logic [ADDR_W-1:0] req_address;
  logic              req_ready;
  logic              busy;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_address;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ready;
  logic [DATA_W-1:0] memory_data;
  logic              memory_data_valid;
  logic [ADDR_W-1:0] memory_address;

  modport master (
    output req_valid, req_address, wr_en, wr_address, wr_data,
    input  req_ready, busy, wr_ready, memory_data, memory_data_valid, memory_address
  );

  modport slave (
    input  req_valid, req_address, wr_en, wr_address, wr_data,
    output req_ready, busy, wr_ready, memory_data, memory_data_valid, memory_address
  );

endinterface

// File: rtl/mem_read_pipe.sv
// Fixed-latency delay line carrying {valid, address, data} for words read
// from the backing array; a synchronous flush drops everything in flight.
module mem_read_pipe
  import mem_pkg::*;
#(
  parameter int LATENCY = LATENCY_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [ADDR_W-1:0] in_address,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  output logic [ADDR_W-1:0] out_address,
  output logic [DATA_W-1:0] out_data
);

  logic [LATENCY-1:0] valid_q;
  logic [ADDR_W-1:0]  address_q [LATENCY];
  logic [DATA_W-1:0]  data_q    [LATENCY];

  // Shift every stage forward one slot per cycle, or clear all stages on flush.
  always_ff @(posedge clk) begin
    if (flush) begin
      valid_q <= '0;
      for (int k = 0; k < LATENCY; k++) begin
        address_q[k] <= '0;
        data_q[k]    <= '0;
      end
    end else begin
      valid_q[0]   <= in_valid;
      address_q[0] <= in_address;
      data_q[0]    <= in_data;
      for (int k = 1; k < LATENCY; k++) begin
        valid_q[k]   <= valid_q[k-1];
        address_q[k] <= address_q[k-1];
        data_q[k]    <= data_q[k-1];
      end
    end
  end

  assign out_valid   = valid_q[LATENCY-1];
  assign out_address = address_q[LATENCY-1];
  assign out_data    = data_q[LATENCY-1];

endmodule

// File: rtl/mem_burst_responder.sv
// Memory-side responder for cache block fills. Owns the backing word array,
// accepts single-word writes while idle, and streams a whole block back one
// word per cycle after a fixed read latency.
// Optional macro FILL_CRITICAL_WORD_FIRST_EN: start the burst at the word
// holding the miss address and wrap within the block; otherwise every burst
// starts at block offset 0.
module mem_burst_responder
  import mem_pkg::*;
#(
  parameter int ADDR_W         = ADDR_W_DEF,
  parameter int DATA_W         = DATA_W_DEF,
  parameter int BURST          = BURST_DEF,
  parameter int LATENCY        = LATENCY_DEF,
  parameter int MEM_WORDS_LOG2 = MEM_WORDS_LOG2_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  mem_burst_responder_if.slave  bus
);

  localparam int OFF_W = $clog2(BURST);
  localparam int CNT_W = OFF_W + 1;
  localparam int DEPTH = 1 << MEM_WORDS_LOG2;

  logic [DATA_W-1:0] mem [DEPTH];

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  issue_cnt, ret_cnt;
  logic [ADDR_W-1:0] base_q;
  logic [OFF_W-1:0]  start_q, start_d;
  logic              accept, wr_take, issue_en;

  logic [OFF_W-1:0]          rd_off;
  logic [ADDR_W-1:0]         rd_address;
  logic [MEM_WORDS_LOG2-1:0] rd_idx, wr_idx;
  logic [ADDR_W-1:0]         pipe_in_address;
  logic [DATA_W-1:0]         pipe_in_data;

  logic              pipe_valid;
  logic [ADDR_W-1:0] pipe_address;
  logic [DATA_W-1:0] pipe_data;

  logic unused_wr_bits;
  assign unused_wr_bits = ^{bus.wr_address[ADDR_W-1:MEM_WORDS_LOG2+1], bus.wr_address[0]};

`ifdef FILL_CRITICAL_WORD_FIRST_EN
  assign start_d = bus.req_address[OFF_W:1];
`else
  assign start_d = '0;
`endif

  assign wr_idx = bus.wr_address[MEM_WORDS_LOG2:1];
  assign rd_idx = rd_address[MEM_WORDS_LOG2:1];
  assign rd_off = start_q + issue_cnt[OFF_W-1:0];

  // Word address of the read being issued: block base plus wrapped offset.
  always_comb begin
    rd_address            = base_q;
    rd_address[OFF_W:1]   = rd_off;
    pipe_in_address       = '0;
    pipe_in_data          = '0;
    if (issue_en) begin
      pipe_in_address = rd_address;
      pipe_in_data    = mem[rd_idx];
    end
  end

  // State register; reset returns to IDLE and abandons any burst.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state and handshakes; writes win over fill requests in IDLE.
  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    wr_take  = 1'b0;
    issue_en = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!rst) begin
          if (bus.wr_en) begin
            wr_take = 1'b1;
          end else if (bus.req_valid) begin
            accept  = 1'b1;
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        issue_en = 1'b1;
        if (issue_cnt == CNT_W'(BURST - 1)) state_d = DRAIN;
      end
      DRAIN: begin
        if (pipe_valid && ret_cnt == CNT_W'(BURST - 1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Latch the block on accept and count issued and returned words.
  always_ff @(posedge clk) begin
    if (rst) begin
      issue_cnt <= '0;
      ret_cnt   <= '0;
      base_q    <= '0;
      start_q   <= '0;
    end else begin
      if (accept) begin
        base_q    <= ADDR_W'(block_base(bus.req_address, OFF_W));
        start_q   <= start_d;
        issue_cnt <= '0;
        ret_cnt   <= '0;
      end else begin
        if (issue_en)   issue_cnt <= issue_cnt + 1'b1;
        if (pipe_valid) ret_cnt   <= ret_cnt + 1'b1;
      end
    end
  end

  // Backing array write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_take) mem[wr_idx] <= bus.wr_data;
  end

  mem_read_pipe #(
    .LATENCY (LATENCY),
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W)
  ) u_read_pipe (
    .clk         (clk),
    .flush       (rst),
    .in_valid    (issue_en),
    .in_address  (pipe_in_address),
    .in_data     (pipe_in_data),
    .out_valid   (pipe_valid),
    .out_address (pipe_address),
    .out_data    (pipe_data)
  );

  assign bus.req_ready         = accept;
  assign bus.wr_ready          = wr_take;
  assign bus.busy              = (state_q != IDLE);
  assign bus.memory_data       = pipe_data;
  assign bus.memory_data_valid = pipe_valid;
  assign bus.memory_address    = pipe_address;

endmodule

// File: tb/tb_mem_burst_responder.sv
// Directed self-checking bench for mem_burst_responder.
// Honours FILL_CRITICAL_WORD_FIRST_EN for the expected word order.
module tb_mem_burst_responder;

  localparam int LAT = 4;
  localparam int BUR = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;

  mem_burst_responder_if #(.ADDR_W(16), .DATA_W(16)) bus ();

  mem_burst_responder dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [15:0] model_mem [0:127];
  logic [15:0] exp_addr  [0:7];

  // Watchdog so the bench can never hang.
  initial begin
    #500000;
    $display("[TB] FAIL timeout: simulation did not complete");
    $fatal(1, "[TB] timeout");
  end

  // Expected word order of a burst for a given miss address.
  task automatic set_expected(input logic [15:0] req);
    logic [15:0] base;
    logic [2:0]  start;
    logic [2:0]  off;
    base = req & 16'hFFF0;
`ifdef FILL_CRITICAL_WORD_FIRST_EN
    start = req[3:1];
`else
    start = 3'd0;
`endif
    for (int i = 0; i < BUR; i++) begin
      off = start + 3'(i);
      exp_addr[i] = base | {12'd0, off, 1'b0};
    end
  endtask

  task automatic start_request(input logic [15:0] addr, input string name);
    @(negedge clk);
    bus.req_valid   = 1'b1;
    bus.req_address = addr;
    #1;
    checks++;
    if (bus.req_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL %s accept: req_ready=%b expected 1", name, bus.req_ready);
    end
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask

  // Called at the negedge of the cycle after accept; walks LAT+BUR+1 cycles.
  task automatic check_burst(input string name, input bit inject);
    int          pulses;
    int          idx;
    logic        exp_busy, exp_valid;
    logic [15:0] a;
    pulses = 0;
    for (int n = 1; n <= LAT + BUR + 1; n++) begin
      if (n > 1) @(negedge clk);
      if (inject && n == LAT + BUR - 2) begin
        bus.req_valid   = 1'b1;
        bus.req_address = 16'h0000;
        bus.wr_en       = 1'b1;
        bus.wr_address  = 16'h0060;
        bus.wr_data     = 16'h5A5A;
      end
      #1;
      exp_busy  = (n <= LAT + BUR);
      exp_valid = (n >= LAT + 1) && (n <= LAT + BUR);
      checks++;
      if (bus.busy !== exp_busy) begin
        errors++;
        $display("[TB] FAIL %s busy n=%0d: got %b expected %b", name, n, bus.busy, exp_busy);
      end
      checks++;
      if (bus.memory_data_valid !== exp_valid) begin
        errors++;
        $display("[TB] FAIL %s valid n=%0d: got %b expected %b", name, n, bus.memory_data_valid, exp_valid);
      end
      if (bus.memory_data_valid === 1'b1) pulses++;
      if (exp_valid && bus.memory_data_valid === 1'b1) begin
        idx = n - LAT - 1;
        a   = exp_addr[idx];
        checks++;
        if (bus.memory_address !== a) begin
          errors++;
          $display("[TB] FAIL %s address word %0d: got %h expected %h", name, idx, bus.memory_address, a);
        end
        checks++;
        if (bus.memory_data !== model_mem[a[7:1]]) begin
          errors++;
          $display("[TB] FAIL %s data word %0d: got %h expected %h", name, idx, bus.memory_data, model_mem[a[7:1]]);
        end
      end
      if (inject && n >= LAT + BUR - 2 && n <= LAT + BUR) begin
        checks++;
        if (bus.req_ready !== 1'b0 || bus.wr_ready !== 1'b0) begin
          errors++;
          $display("[TB] FAIL %s blocked n=%0d: req_ready=%b wr_ready=%b expected 0 0", name, n, bus.req_ready, bus.wr_ready);
        end
      end
      if (inject && n == LAT + BUR + 1) begin
        checks++;
        if (bus.wr_ready !== 1'b1 || bus.req_ready !== 1'b0) begin
          errors++;
          $display("[TB] FAIL %s held write: wr_ready=%b req_ready=%b expected 1 0", name, bus.wr_ready, bus.req_ready);
        end
        model_mem[7'h30] = 16'h5A5A;
      end
    end
    checks++;
    if (pulses != BUR) begin
      errors++;
      $display("[TB] FAIL %s pulse count: got %0d expected %0d", name, pulses, BUR);
    end
  endtask

  task automatic test_reset;
    bus.req_valid   = 1'b1;
    bus.req_address = 16'h0000;
    bus.wr_en       = 1'b1;
    bus.wr_address  = 16'h0000;
    bus.wr_data     = 16'h0000;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (bus.req_ready !== 1'b0 || bus.wr_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset ready: req_ready=%b wr_ready=%b expected 0 0", bus.req_ready, bus.wr_ready);
    end
    checks++;
    if (bus.busy !== 1'b0 || bus.memory_data_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset busy/valid: busy=%b valid=%b expected 0 0", bus.busy, bus.memory_data_valid);
    end
    checks++;
    if (bus.memory_data !== 16'h0000 || bus.memory_address !== 16'h0000) begin
      errors++;
      $display("[TB] FAIL reset data/address: data=%h address=%h expected 0000 0000", bus.memory_data, bus.memory_address);
    end
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.wr_en     = 1'b0;
    rst           = 1'b0;
  endtask

  task automatic preload;
    int bad;
    bad = 0;
    for (int k = 0; k < 128; k++) begin
      @(negedge clk);
      bus.wr_en      = 1'b1;
      bus.wr_address = 16'(2 * k);
      bus.wr_data    = 16'hA000 + 16'(k);
      #1;
      if (bus.wr_ready !== 1'b1) bad++;
      model_mem[k] = 16'hA000 + 16'(k);
    end
    @(negedge clk);
    bus.wr_en = 1'b0;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("[TB] FAIL preload wr_ready: got %0d refusals expected 0", bad);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_burst_offset0;
    start_request(16'h0036, "burst0");
    set_expected(16'h0036);
    check_burst("burst0", 1'b0);
  endtask

  task automatic test_write_readback;
    @(negedge clk);
    bus.wr_en      = 1'b1;
    bus.wr_address = 16'h0042;
    bus.wr_data    = 16'hBEEF;
    #1;
    checks++;
    if (bus.wr_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL readback write: wr_ready=%b expected 1", bus.wr_ready);
    end
    model_mem[7'h21] = 16'hBEEF;
    @(negedge clk);
    bus.wr_en = 1'b0;
    bus.req_valid   = 1'b0;
    start_request(16'h0040, "readback");
    set_expected(16'h0040);
    check_burst("readback", 1'b0);
  endtask

  task automatic test_collision;
    @(negedge clk);
    bus.wr_en       = 1'b1;
    bus.wr_address  = 16'h0054;
    bus.wr_data     = 16'h1234;
    bus.req_valid   = 1'b1;
    bus.req_address = 16'h0050;
    #1;
    checks++;
    if (bus.wr_ready !== 1'b1 || bus.req_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL collision first cycle: wr_ready=%b req_ready=%b expected 1 0", bus.wr_ready, bus.req_ready);
    end
    model_mem[7'h2A] = 16'h1234;
    @(negedge clk);
    bus.wr_en = 1'b0;
    #1;
    checks++;
    if (bus.req_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL collision accept: req_ready=%b expected 1", bus.req_ready);
    end
    @(negedge clk);
    bus.req_valid = 1'b0;
    set_expected(16'h0050);
    check_burst("collision", 1'b0);
  endtask

  task automatic test_back_to_back;
    start_request(16'h0020, "busy");
    set_expected(16'h0020);
    check_burst("busy", 1'b1);
    @(negedge clk);
    bus.wr_en = 1'b0;
    #1;
    checks++;
    if (bus.req_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL held request accept: req_ready=%b expected 1", bus.req_ready);
    end
    @(negedge clk);
    bus.req_valid = 1'b0;
    set_expected(16'h0000);
    check_burst("b2b", 1'b0);
  endtask

  task automatic test_reset_mid_burst;
    int stray;
    logic [15:0] a;
    start_request(16'h0060, "midreset");
    set_expected(16'h0060);
    for (int n = 1; n <= LAT + 3; n++) begin
      if (n > 1) @(negedge clk);
      #1;
      if (n > LAT) begin
        a = exp_addr[n - LAT - 1];
        checks++;
        if (bus.memory_data_valid !== 1'b1 || bus.memory_data !== model_mem[a[7:1]]) begin
          errors++;
          $display("[TB] FAIL midreset word %0d: valid=%b data=%h expected 1 %h", n - LAT - 1, bus.memory_data_valid, bus.memory_data, model_mem[a[7:1]]);
        end
      end
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (bus.memory_data_valid !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midreset after: valid=%b busy=%b expected 0 0", bus.memory_data_valid, bus.busy);
    end
    checks++;
    if (bus.memory_data !== 16'h0000 || bus.memory_address !== 16'h0000) begin
      errors++;
      $display("[TB] FAIL midreset outputs: data=%h address=%h expected 0000 0000", bus.memory_data, bus.memory_address);
    end
    stray = 0;
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      #1;
      if (bus.memory_data_valid !== 1'b0 || bus.busy !== 1'b0) stray++;
    end
    checks++;
    if (stray != 0) begin
      errors++;
      $display("[TB] FAIL midreset stray pulses: got %0d expected 0", stray);
    end
    start_request(16'h0060, "midreset_again");
    set_expected(16'h0060);
    check_burst("midreset_again", 1'b0);
  endtask

  task automatic test_critical_word;
    start_request(16'h001A, "cwf");
`ifdef FILL_CRITICAL_WORD_FIRST_EN
    exp_addr = '{16'h001A, 16'h001C, 16'h001E, 16'h0010, 16'h0012, 16'h0014, 16'h0016, 16'h0018};
`else
    exp_addr = '{16'h0010, 16'h0012, 16'h0014, 16'h0016, 16'h0018, 16'h001A, 16'h001C, 16'h001E};
`endif
    check_burst("cwf", 1'b0);
  endtask

  initial begin
    bus.req_valid   = 1'b0;
    bus.req_address = 16'h0000;
    bus.wr_en       = 1'b0;
    bus.wr_address  = 16'h0000;
    bus.wr_data     = 16'h0000;
    test_reset();
    preload();
    test_burst_offset0();
    test_write_readback();
    test_collision();
    test_back_to_back();
    test_reset_mid_burst();
    test_critical_word();
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
